// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA raster generator.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam bit SYNC_POL_DEF = 1'b0;

    // Largest legal line/frame total that an 11-bit coordinate can hold.
    localparam int COORD_MAX = 2047;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_phase_e;
    typedef logic [10:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator (master) and its consumers (slave).
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic        pixelCE;
    coord_t      pixelX;
    coord_t      pixelY;
    logic        hSync;
    logic        vSync;
    logic        blankN;
    logic        startOfFrame;
    logic [15:0] frameCount;

    modport master (
        input  pixelCE,
        output pixelX, pixelY, hSync, vSync, blankN, startOfFrame, frameCount
    );

    modport slave (
        output pixelCE,
        input  pixelX, pixelY, hSync, vSync, blankN, startOfFrame, frameCount
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// state  | meaning
// ACTIVE | visible pixels/lines
// FRONT  | front porch
// SYNC   | sync pulse
// BACK   | back porch
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = H_ACTIVE_DEF,
    parameter int FRONT_LEN  = H_FRONT_DEF,
    parameter int SYNC_LEN   = H_SYNC_DEF,
    parameter int BACK_LEN   = H_BACK_DEF
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        advance,
    output coord_t      count,
    output axis_phase_e phase,
    output axis_phase_e phase_nxt,
    output logic        wrap
);

    localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

    if (TOTAL > COORD_MAX || ACTIVE_LEN < 1 || FRONT_LEN < 1 || SYNC_LEN < 1 || BACK_LEN < 1)
    begin : g_bad_params
        $error("vga_axis_counter: illegal timing parameters (total must be <= 2047, phases >= 1)");
    end

    localparam coord_t END_ACTIVE = coord_t'(ACTIVE_LEN - 1);
    localparam coord_t END_FRONT  = coord_t'(ACTIVE_LEN + FRONT_LEN - 1);
    localparam coord_t END_SYNC   = coord_t'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
    localparam coord_t END_TOTAL  = coord_t'(TOTAL - 1);

    assign wrap = advance && (count == END_TOTAL);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase <= ACTIVE;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Each phase hands over on its own last pixel, so phase tracks count exactly.
    always_comb begin
        phase_nxt = phase;
        if (advance) begin
            case (phase)
                ACTIVE:  if (count == END_ACTIVE) phase_nxt = FRONT;
                FRONT:   if (count == END_FRONT)  phase_nxt = SYNC;
                SYNC:    if (count == END_SYNC)   phase_nxt = BACK;
                BACK:    if (count == END_TOTAL)  phase_nxt = ACTIVE;
                default: phase_nxt = ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: scan coordinates, syncs, blank and frame strobe.
// Optional frame counter is built only when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF
) (
    input logic               clk,
    input logic               resetN,
    vga_timing_gen_if.master  vga
);

    coord_t      h_count;
    coord_t      v_count;
    axis_phase_e h_phase;
    axis_phase_e h_phase_nxt;
    axis_phase_e v_phase;
    axis_phase_e v_phase_nxt;
    logic        h_wrap;
    logic        v_wrap;
    logic        frame_wrap;

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FRONT_LEN  (H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BACK)
    ) u_h_axis (
        .clk       (clk),
        .resetN    (resetN),
        .advance   (vga.pixelCE),
        .count     (h_count),
        .phase     (h_phase),
        .phase_nxt (h_phase_nxt),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FRONT_LEN  (V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_BACK)
    ) u_v_axis (
        .clk       (clk),
        .resetN    (resetN),
        .advance   (h_wrap),
        .count     (v_count),
        .phase     (v_phase),
        .phase_nxt (v_phase_nxt),
        .wrap      (v_wrap)
    );

    assign frame_wrap = h_wrap && v_wrap;
    assign vga.pixelX = h_count;
    assign vga.pixelY = v_count;

    // Decoded from next-phase so the flops update on the same edge as the counters.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vga.hSync        <= ~SYNC_POL;
            vga.vSync        <= ~SYNC_POL;
            vga.blankN       <= 1'b0;
            vga.startOfFrame <= 1'b0;
        end else begin
            vga.startOfFrame <= frame_wrap;
            if (vga.pixelCE) begin
                vga.hSync  <= (h_phase_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
                vga.vSync  <= (v_phase_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
                vga.blankN <= (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign vga.frameCount = frame_cnt;
`else
    assign vga.frameCount = 16'h0;
`endif

    a_hsync_phase: assert property (@(posedge clk) disable iff (!resetN)
        (vga.hSync == SYNC_POL) == (h_phase == SYNC));
    a_vsync_phase: assert property (@(posedge clk) disable iff (!resetN)
        (vga.vSync == SYNC_POL) == (v_phase == SYNC));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing and reduced-timing instances against a position-count model.
module tb_vga_timing_gen;

    localparam int unsigned SHA = 16, SHF = 4, SHS = 6, SHB = 6;
    localparam int unsigned SVA = 12, SVF = 2, SVS = 2, SVB = 3;
    localparam int unsigned DHA = 640, DHF = 16, DHS = 96, DHB = 48;
    localparam int unsigned DVA = 480, DVF = 10, DVS = 2, DVB = 33;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        sof;
        logic [15:0] fc;
    } ras_t;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    logic pce    = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;
    int   mode     = 0;
    int   e        = 0;
    int   cyc      = 0;

    int unsigned n_ce    = 0;
    bit          last_ce = 1'b0;

    initial forever #5 clk = ~clk;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_s ();

    assign if_d.pixelCE = pce;
    assign if_s.pixelCE = pce;

    vga_timing_gen u_dut_d (
        .clk    (clk),
        .resetN (resetN),
        .vga    (if_d.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (SHA), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_ACTIVE (SVA), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .SYNC_POL (1'b0)
    ) u_dut_s (
        .clk    (clk),
        .resetN (resetN),
        .vga    (if_s.master)
    );

    // Model state: pixel-enable edges seen since reset, and whether the last clk had one.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            n_ce    = 0;
            last_ce = 1'b0;
        end else begin
            cyc++;
            last_ce = pce;
            if (pce) n_ce++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (mode)
            0:       pce = 1'b1;
            1:       pce = ~pce;
            default: pce = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic ras_t model(input int unsigned n, input bit ce,
                                   input int unsigned ha, input int unsigned hf,
                                   input int unsigned hs, input int unsigned hb,
                                   input int unsigned va, input int unsigned vf,
                                   input int unsigned vs, input int unsigned vb);
        ras_t        r;
        int unsigned ht = ha + hf + hs + hb;
        int unsigned vt = va + vf + vs + vb;
        int unsigned fr = ht * vt;
        int unsigned h  = n % ht;
        int unsigned v  = (n / ht) % vt;
        r.x   = 11'(h);
        r.y   = 11'(v);
        r.hs  = !((h >= ha + hf) && (h < ha + hf + hs));
        r.vs  = !((v >= va + vf) && (v < va + vf + vs));
        r.bn  = (n != 0) && (h < ha) && (v < va);
        r.sof = ce && (n != 0) && (n % fr == 0);
`ifdef VGA_FRAME_COUNT_EN
        r.fc  = 16'((n / fr) % 65536);
`else
        r.fc  = 16'h0;
`endif
        return r;
    endfunction

    function automatic ras_t act_d();
        return {if_d.pixelX, if_d.pixelY, if_d.hSync, if_d.vSync, if_d.blankN,
                if_d.startOfFrame, if_d.frameCount};
    endfunction

    function automatic ras_t act_s();
        return {if_s.pixelX, if_s.pixelY, if_s.hSync, if_s.vSync, if_s.blankN,
                if_s.startOfFrame, if_s.frameCount};
    endfunction

    task automatic cmp_ras(input string nm, input ras_t a, input ras_t x);
        n_checks++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b bn=%b sof=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b bn=%b sof=%b fc=%0d",
                     nm, $time, a.x, a.y, a.hs, a.vs, a.bn, a.sof, a.fc,
                     x.x, x.y, x.hs, x.vs, x.bn, x.sof, x.fc);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        n_checks++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, a, x);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s @%0t: timed out", nm, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_ras("raster_default", act_d(), model(n_ce, last_ce, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB));
            cmp_ras("raster_small",   act_s(), model(n_ce, last_ce, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
        end
    end

    task automatic adv(input int to);
        repeat (to - e) @(posedge clk);
        e = to;
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_d_x"},   32'(if_d.pixelX), 0);
        chk({tag, "_d_y"},   32'(if_d.pixelY), 0);
        chk({tag, "_d_hs"},  32'(if_d.hSync), 1);
        chk({tag, "_d_vs"},  32'(if_d.vSync), 1);
        chk({tag, "_d_bn"},  32'(if_d.blankN), 0);
        chk({tag, "_d_sof"}, 32'(if_d.startOfFrame), 0);
        chk({tag, "_d_fc"},  32'(if_d.frameCount), 0);
        chk({tag, "_s_x"},   32'(if_s.pixelX), 0);
        chk({tag, "_s_y"},   32'(if_s.pixelY), 0);
        chk({tag, "_s_hs"},  32'(if_s.hSync), 1);
        chk({tag, "_s_bn"},  32'(if_s.blankN), 0);
        chk({tag, "_s_fc"},  32'(if_s.frameCount), 0);
    endtask

    task automatic wait_sof_s(input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (if_s.startOfFrame === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int  t0;
        int  t1;
        bit  ok;

        mode   = 0;
        resetN = 1'b0;
        pce    = 1'b1;
        #22;
        chk_reset_vals("por");
        chk_en = 1'b1;
        @(negedge clk);
        resetN = 1'b1;

        // Continuous pixel enable: hand-computed checkpoints.
        adv(1);
        chk("d_first_x", 32'(if_d.pixelX), 1);
        chk("d_first_y", 32'(if_d.pixelY), 0);
        chk("d_first_bn", 32'(if_d.blankN), 1);
        adv(448);
        chk("s_vs_fall_y", 32'(if_s.pixelY), 14);
        chk("s_vs_fall", 32'(if_s.vSync), 0);
        adv(512);
        chk("s_vs_rise_y", 32'(if_s.pixelY), 16);
        chk("s_vs_rise", 32'(if_s.vSync), 1);
        adv(608);
        chk("s_sof1", 32'(if_s.startOfFrame), 1);
        chk("s_sof1_x", 32'(if_s.pixelX), 0);
        chk("s_sof1_y", 32'(if_s.pixelY), 0);
        adv(609);
        chk("s_sof1_clr", 32'(if_s.startOfFrame), 0);
        adv(639);
        chk("d_bn_639", 32'(if_d.blankN), 1);
        adv(640);
        chk("d_bn_640", 32'(if_d.blankN), 0);
        chk("d_x_640", 32'(if_d.pixelX), 640);
        adv(655);
        chk("d_hs_655", 32'(if_d.hSync), 1);
        adv(656);
        chk("d_hs_656", 32'(if_d.hSync), 0);
        adv(751);
        chk("d_hs_751", 32'(if_d.hSync), 0);
        adv(752);
        chk("d_hs_752", 32'(if_d.hSync), 1);
        adv(799);
        chk("d_x_799", 32'(if_d.pixelX), 799);
        chk("d_y_799", 32'(if_d.pixelY), 0);
        adv(800);
        chk("d_wrap_x", 32'(if_d.pixelX), 0);
        chk("d_wrap_y", 32'(if_d.pixelY), 1);
        adv(1216);
        chk("s_sof2", 32'(if_s.startOfFrame), 1);
        adv(1824);
        chk("s_sof3", 32'(if_s.startOfFrame), 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("s_fc_3frames", 32'(if_s.frameCount), 3);
`else
        chk("s_fc_3frames", 32'(if_s.frameCount), 0);
`endif

        // Alternating pixel enable: a frame spans twice as many clks.
        mode = 1;
        wait_sof_s(2000, t0, ok);
        if (!ok) fail_now("toggle_sof_a");
        @(negedge clk);
        chk("toggle_sof_width", 32'(if_s.startOfFrame), 0);
        wait_sof_s(3000, t1, ok);
        if (!ok) fail_now("toggle_sof_b");
        else chk("toggle_frame_clks", 32'(t1 - t0), 1216);

        mode = 2;
        repeat (3000) @(posedge clk);

        // Mid-frame reset on the small raster at (20,10).
        mode = 0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (if_s.pixelX == 11'd20 && if_s.pixelY == 11'd10) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("reach_20_10");
        #2;
        resetN = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_restart_s_x", 32'(if_s.pixelX), 1);
        chk("rst_restart_s_y", 32'(if_s.pixelY), 0);
        chk("rst_restart_d_x", 32'(if_d.pixelX), 1);

        mode = 2;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
